// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a combinational program ROM from a registered
// fetch PC and queues {instruction, address} pairs in a small prefetch buffer.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  output logic [15:0]              rom_addr,
  input  logic [15:0]              rom_data,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [15:0]              instr,
  output logic [15:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [15:0]   fetch_pc_reg;
  logic [15:0]   fetch_pc_next;
  logic [AW-1:0] head_reg;
  logic [AW-1:0] head_next;
  logic [AW-1:0] tail_reg;
  logic [AW-1:0] tail_next;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;

  logic [15:0]   instr_mem [DEPTH];
  logic [15:0]   pc_mem    [DEPTH];

  logic          pop;
  logic          push;

  // Handshake qualifiers; a full buffer may still accept a word when the head leaves.
  always_comb begin
    pop  = (count_reg != '0) & instr_ready;
    push = fetch_en & ~redirect & ((count_reg < FULL_COUNT) | pop);
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    if (redirect) begin
      // Flush wins over everything; the head is dropped, not delivered.
      fetch_pc_next = redirect_pc;
      head_next     = '0;
      tail_next     = '0;
      count_next    = '0;
    end else begin
      if (push) begin
        fetch_pc_next = fetch_pc_reg + 16'd1;
        tail_next     = tail_reg + 1'b1;
      end
      if (pop) begin
        head_next = head_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
    end
  end

  // Storage carries no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_reg] <= rom_data;
      pc_mem[tail_reg]    <= fetch_pc_reg;
    end
  end

  assign rom_addr    = fetch_pc_reg;
  assign instr_valid = (count_reg != '0);
  assign instr       = instr_mem[head_reg];
  assign instr_pc    = pc_mem[head_reg];
  assign fifo_count  = count_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch, checked against a queue-based model of the prefetch buffer.
module tb_instr_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  fifo_count;

  logic        rom_mode = 1'b0;
  logic [15:0] salt     = 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_q[$];
  logic [15:0] model_pc;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(input logic [15:0] a);
    logic [15:0] prod;
    prod = a * 16'h9E37;
    return rom_mode ? (prod ^ salt) : (16'hA000 + a);
  endfunction

  assign rom_data = rom_val(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one rising edge, using the inputs that were stable before it.
  task automatic model_edge();
    bit popv;
    bit pushv;
    if (redirect) begin
      model_q.delete();
      model_pc = redirect_pc;
    end else begin
      popv  = (model_q.size() > 0) && instr_ready;
      pushv = fetch_en && ((model_q.size() < DEPTH) || popv);
      if (popv) void'(model_q.pop_front());
      if (pushv) begin
        model_q.push_back({rom_val(model_pc), model_pc});
        model_pc = model_pc + 16'd1;
      end
    end
  endtask

  task automatic compare();
    check("valid", 32'(instr_valid), 32'(model_q.size() != 0));
    check("count", 32'(fifo_count), 32'(model_q.size()));
    check("rom_addr", 32'(rom_addr), 32'(model_pc));
    if (model_q.size() != 0) begin
      check("instr", 32'(instr), 32'(model_q[0][31:16]));
      check("instr_pc", 32'(instr_pc), 32'(model_q[0][15:0]));
    end
    $display("[TB] t=%0t en=%0b rdy=%0b rd=%0b pc=%h cnt=%0d head_pc=%h", $time,
             fetch_en, instr_ready, redirect, rom_addr, fifo_count, instr_pc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Assert reset between edges and check it takes effect without a clock.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    model_pc = RESET_PC;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'(RESET_PC));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_en    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b1;
    model_pc    = RESET_PC;
    #1;
    check("por_valid", 32'(instr_valid), 32'd0);
    check("por_count", 32'(fifo_count), 32'd0);
    check("por_rom_addr", 32'(rom_addr), 32'(RESET_PC));
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with constant ready.
    step();
    check("stream_first_pc", 32'(instr_pc), 32'h0000);
    check("stream_first_instr", 32'(instr), 32'hA000);
    repeat (10) step();

    // Backpressure from a fresh reset.
    do_reset();
    instr_ready = 1'b0;
    repeat (10) step();
    check("bp_count", 32'(fifo_count), 32'd4);
    check("bp_rom_addr", 32'(rom_addr), 32'h0004);
    check("bp_head_pc", 32'(instr_pc), 32'h0000);
    instr_ready = 1'b1;
    repeat (8) step();

    // Redirect with a full buffer.
    instr_ready = 1'b0;
    repeat (5) step();
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step();
    check("rd_count", 32'(fifo_count), 32'd0);
    check("rd_rom_addr", 32'(rom_addr), 32'h0040);
    redirect = 1'b0;
    step();
    check("rd_head_pc", 32'(instr_pc), 32'h0040);
    repeat (3) step();

    // Address wrap.
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    repeat (5) step();

    // Reset with three entries buffered.
    redirect    = 1'b1;
    redirect_pc = 16'h1234;
    step();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    repeat (3) step();
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    do_reset();
    instr_ready = 1'b1;
    repeat (3) step();

    // Fetch gating drains the buffer and freezes the address.
    fetch_en = 1'b0;
    repeat (5) step();
    check("gate_count", 32'(fifo_count), 32'd0);
    fetch_en = 1'b1;
    repeat (3) step();

    // Randomized traffic over a scrambled ROM image.
    rom_mode = 1'b1;
    salt     = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      fetch_en    = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 4) < 3);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
